stopwatch_counter: RTL and testbench
====================================

STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 SHALL provide parameter TICK_DIV, default 10000000, meaning clock cycles per 0.1 s count step (100 MHz clock); legal range 2..2^24.
REQ-002 SHALL provide port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port start_stop  input  1  debounced, clk-synchronous button level; acts on its rising edge only.
REQ-005 SHALL provide port clear  input  1  synchronous level; while high, holds the counter at zero in IDLE.
REQ-006 SHALL provide port tenths  output  4  BCD tenths-of-second digit, 0..9, fed to a BCD 7-segment decoder.
REQ-007 SHALL provide port sec_ones  output  4  BCD seconds-units digit, 0..9.
REQ-008 SHALL provide port sec_tens  output  4  BCD seconds-tens digit, 0..5.
REQ-009 SHALL provide port minutes  output  4  BCD minutes digit, 0..9.
REQ-010 SHALL provide port running  output  1  high while the FSM is in RUNNING.
REQ-011 SHALL provide port wrap  output  1  one-cycle pulse when the count rolls from 9:59.9 to 0:00.0.

Function
REQ-012 SHALL implement FSM states IDLE (zero, stopped), RUNNING and PAUSED (held, non-zero allowed).
REQ-013 SHALL register start_stop each cycle; a press event is start_stop=1 with the registered value 0; a held level produces exactly one event.
REQ-014 SHALL transition on a press event: IDLE->RUNNING, RUNNING->PAUSED, PAUSED->RUNNING, with the new state visible after that edge.
REQ-015 SHALL, with clear=1 at an edge, enter IDLE and zero all digits and the prescaler from any state; clear overrides a simultaneous press event and tick.
REQ-016 SHALL hold a 24-bit prescaler that advances only in RUNNING, counting 0..TICK_DIV-1 and returning to 0 after TICK_DIV-1.
REQ-017 SHALL assert an internal tick for the cycle in which the prescaler equals TICK_DIV-1 in RUNNING; digits update at that same edge.
REQ-018 SHALL retain the prescaler value in PAUSED, so that the resumed interval completes the partial step.
REQ-019 SHALL zero the prescaler on the IDLE->RUNNING transition.
REQ-020 SHALL increment tenths on each tick; at 9 it becomes 0 and carries into sec_ones.
REQ-021 SHALL roll sec_ones 9->0 with carry into sec_tens, roll sec_tens 5->0 with carry into minutes, and roll minutes 9->0.
REQ-022 SHALL, on the tick at 9:59.9, produce 0:00.0, pulse wrap high for exactly one cycle and remain in RUNNING.
REQ-023 SHALL never output a digit value outside its stated range, including after any press or clear sequence.
REQ-024 SHALL register all outputs, with no combinational path from any input to any output.
REQ-025 SHALL leave the digits unchanged in PAUSED and IDLE except through clear or reset.

Reset
REQ-026 SHALL, while reset=1, asynchronously force IDLE, all digits to 0, the prescaler to 0, the start_stop register to 0, running=0 and wrap=0.
REQ-027 SHALL, after reset deasserts, take no action until the next press event; a start_stop level already high at deassertion counts as a press on the first edge.
REQ-028 SHALL, on reset asserted mid-count or mid-wrap, abandon the count immediately, with no wrap pulse afterward.

Verification (TICK_DIV=4)
REQ-029 SHALL pass: reset, then a 1-cycle start_stop press -> running=1 next edge; after 4 cycles tenths=1; after 40 cycles sec_ones=1, tenths=0.
REQ-030 SHALL pass: run 2 cycles into a step, press to pause for 10 cycles, then press again -> digits frozen while paused; tenths increments exactly 2 cycles after resume.
REQ-031 SHALL pass: start_stop held high for 20 cycles from IDLE -> a single transition to RUNNING; no pause occurs.
REQ-032 SHALL pass: preload by running to 9:59.9 -> the next tick gives 0:00.0, wrap=1 for one cycle, running stays 1.
REQ-033 SHALL pass: clear and a press event in the same cycle during RUNNING at 0:12.3 -> IDLE, all digits 0, running=0.
REQ-034 SHALL pass: reset asserted between edges during RUNNING -> outputs zero without waiting for a clock edge; running=0.

Source files
------------

// File: rtl/stopwatch_counter.sv
// ---------------------------------------------------------------------------
// stopwatch_counter
//   Start/stop stopwatch with a 0.1 s resolution and a range of 0:00.0..9:59.9.
//   The prescaler divides clk by TICK_DIV to make the 0.1 s step. A BCD digit
//   chain advances on each step and rolls over from 9:59.9 to 0:00.0.
//
// Parameters
//   TICK_DIV   : clk cycles per 0.1 s step (2..2^24)
//
// Ports
//   clk        : in  clock; all state changes on its rising edge
//   reset      : in  asynchronous active-high reset
//   start_stop : in  debounced button level; only its rising edge has an effect
//   clear      : in  synchronous; forces IDLE and zero, and wins over a press
//   tenths     : out BCD 0..9
//   sec_ones   : out BCD 0..9
//   sec_tens   : out BCD 0..5
//   minutes    : out BCD 0..9
//   running    : out high while in RUNNING
//   wrap       : out one-cycle pulse on the 9:59.9 -> 0:00.0 rollover
// ---------------------------------------------------------------------------
module stopwatch_counter #(
    parameter int unsigned TICK_DIV = 10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] tenths,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] minutes,
    output logic       running,
    output logic       wrap
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } state_t;

    localparam logic [23:0] LAST = 24'(TICK_DIV - 1);

    state_t      state_q, state_d;
    logic        ss_q;
    logic        press;
    logic        tick;
    logic [23:0] presc, presc_d;
    logic [3:0]  t_d, so_d, st_d, m_d;
    logic        wrap_d;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state, prescaler and digit chain
    always_comb begin
        state_d = state_q;
        presc_d = presc;
        t_d     = tenths;
        so_d    = sec_ones;
        st_d    = sec_tens;
        m_d     = minutes;
        wrap_d  = 1'b0;

        // A press needs the previous registered level to be low, so a held
        // button gives exactly one event.
        press = start_stop & ~ss_q;
        tick  = (state_q == RUNNING) && (presc == LAST);

        if (state_q == RUNNING) begin
            if (tick) begin
                presc_d = '0;
                // Use >= compares so an out-of-range digit cannot get stuck.
                if (tenths >= 4'd9) begin
                    t_d = 4'd0;
                    if (sec_ones >= 4'd9) begin
                        so_d = 4'd0;
                        if (sec_tens >= 4'd5) begin
                            st_d = 4'd0;
                            if (minutes >= 4'd9) m_d = 4'd0;
                            else                 m_d = minutes + 4'd1;
                        end else begin
                            st_d = sec_tens + 4'd1;
                        end
                    end else begin
                        so_d = sec_ones + 4'd1;
                    end
                end else begin
                    t_d = tenths + 4'd1;
                end
                wrap_d = (minutes >= 4'd9) && (sec_tens >= 4'd5) &&
                         (sec_ones >= 4'd9) && (tenths >= 4'd9);
            end else begin
                presc_d = presc + 24'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (press) begin
                    state_d = RUNNING;
                    presc_d = '0;
                end
            end
            RUNNING: if (press) state_d = PAUSED;
            PAUSED:  if (press) state_d = RUNNING;
            default: state_d = IDLE;
        endcase

        // Clear overrides a press and a tick in the same cycle.
        if (clear) begin
            state_d = IDLE;
            presc_d = '0;
            t_d     = 4'd0;
            so_d    = 4'd0;
            st_d    = 4'd0;
            m_d     = 4'd0;
            wrap_d  = 1'b0;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ss_q     <= 1'b0;
            presc    <= '0;
            tenths   <= 4'd0;
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            minutes  <= 4'd0;
            running  <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            ss_q     <= start_stop;
            presc    <= presc_d;
            tenths   <= t_d;
            sec_ones <= so_d;
            sec_tens <= st_d;
            minutes  <= m_d;
            running  <= (state_d == RUNNING);
            wrap     <= wrap_d;
        end
    end

endmodule

// File: tb/tb_stopwatch_counter.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_counter
//   Directed testbench for stopwatch_counter with TICK_DIV=4. Inputs are
//   driven 1 ns after a rising edge, and outputs are sampled at the same point.
//   Digits are compared packed as {minutes,sec_tens,sec_ones,tenths}.
// ---------------------------------------------------------------------------
module tb_stopwatch_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] tenths, sec_ones, sec_tens, minutes;
    logic       running, wrap;

    int errors = 0;
    int checks = 0;

    stopwatch_counter #(.TICK_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_stop (start_stop),
        .clear      (clear),
        .tenths     (tenths),
        .sec_ones   (sec_ones),
        .sec_tens   (sec_tens),
        .minutes    (minutes),
        .running    (running),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] digits();
        return {minutes, sec_tens, sec_ones, tenths};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, ending 1 ns after the last edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle press
    task automatic press();
        start_stop = 1'b1;
        cyc(1);
        start_stop = 1'b0;
    endtask

    initial begin
        // Reset state
        cyc(3);
        chk("rst_digits", 32'(digits()), 32'h0000);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        reset = 1'b0;
        cyc(2);
        chk("idle_no_action", 32'(running), 32'd0);

        // Basic counting
        press();
        chk("start_running", 32'(running), 32'd1);
        cyc(4);
        chk("first_tenth", 32'(digits()), 32'h0001);
        cyc(36);
        chk("one_second", 32'(digits()), 32'h0010);

        // Pause mid-step: the press edge leaves the prescaler at 2
        cyc(1);
        press();
        chk("paused", 32'(running), 32'd0);
        cyc(10);
        chk("pause_frozen", 32'(digits()), 32'h0010);
        chk("pause_still", 32'(running), 32'd0);
        press();
        chk("resumed", 32'(running), 32'd1);
        cyc(1);
        chk("resume_1cyc", 32'(digits()), 32'h0010);
        cyc(1);
        chk("resume_2cyc", 32'(digits()), 32'h0011);

        // Held level gives a single press event
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        chk("clear_digits", 32'(digits()), 32'h0000);
        chk("clear_running", 32'(running), 32'd0);
        start_stop = 1'b1;
        cyc(20);
        chk("held_running", 32'(running), 32'd1);
        chk("held_digits", 32'(digits()), 32'h0004);
        start_stop = 1'b0;

        // Wrap from 9:59.9
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        press();
        cyc(2400);
        chk("one_minute", 32'(digits()), 32'h1000);
        cyc(23996 - 2400);
        chk("pre_wrap", 32'(digits()), 32'h9599);
        chk("pre_wrap_flag", 32'(wrap), 32'd0);
        cyc(3);
        chk("pre_wrap_hold", 32'(digits()), 32'h9599);
        cyc(1);
        chk("wrap_digits", 32'(digits()), 32'h0000);
        chk("wrap_pulse", 32'(wrap), 32'd1);
        chk("wrap_running", 32'(running), 32'd1);
        cyc(1);
        chk("wrap_one_cycle", 32'(wrap), 32'd0);
        chk("wrap_still_run", 32'(running), 32'd1);

        // Clear together with a press while running at 0:12.3
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        press();
        cyc(492);
        chk("at_12_3", 32'(digits()), 32'h0123);
        clear = 1'b1;
        start_stop = 1'b1;
        cyc(1);
        clear = 1'b0;
        start_stop = 1'b0;
        chk("clr_press_digits", 32'(digits()), 32'h0000);
        chk("clr_press_running", 32'(running), 32'd0);

        // Asynchronous reset between edges
        cyc(1);
        press();
        cyc(8);
        chk("pre_reset", 32'(digits()), 32'h0002);
        #2;
        reset = 1'b1;
        #1;
        chk("async_digits", 32'(digits()), 32'h0000);
        chk("async_running", 32'(running), 32'd0);

        // Level already high when reset releases counts as a press
        start_stop = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(1);
        chk("post_reset_press", 32'(running), 32'd1);
        start_stop = 1'b0;
        cyc(4);
        chk("post_reset_count", 32'(digits()), 32'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
